// File: rtl/coin_seq_pkg.sv
// rtl/coin_seq_pkg.sv - shared states, default frame lengths and player encoding for the coin/start sequencer
package coin_seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COIN_ON  = 3'd1,
        COIN_GAP = 3'd2,
        START_ON = 3'd3,
        RELEASE  = 3'd4
    } seq_state_t;

    typedef enum logic {
        PLAYER_1 = 1'b0,
        PLAYER_2 = 1'b1
    } player_t;

    localparam int unsigned DEF_COIN_FRAMES  = 3;
    localparam int unsigned DEF_GAP_FRAMES   = 5;
    localparam int unsigned DEF_START_FRAMES = 3;
    localparam int unsigned DEF_CNT_W        = 8;

endpackage

// File: rtl/vblank_tick.sv
// rtl/vblank_tick.sv - ce_pix-qualified vblank rising-edge detector, one clk_sys pulse per frame
module vblank_tick (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic ce_pix,
    input  logic vblank,
    output logic tick
);

    logic vblank_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            vblank_q <= 1'b0;
        end else if (ce_pix) begin
            vblank_q <= vblank;
        end
    end

    assign tick = ce_pix & vblank & ~vblank_q;

endmodule

// File: rtl/coin_start_sequencer.sv
// rtl/coin_start_sequencer.sv - turns one start request into frame-timed coin and start pulses for the core
module coin_start_sequencer
    import coin_seq_pkg::*;
#(
    parameter int unsigned COIN_FRAMES  = DEF_COIN_FRAMES,
    parameter int unsigned GAP_FRAMES   = DEF_GAP_FRAMES,
    parameter int unsigned START_FRAMES = DEF_START_FRAMES,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic ce_pix,
    input  logic vblank,
    input  logic req_start1,
    input  logic req_start2,
    input  logic coin_btn,
    output logic coin_out,
    output logic start1_out,
    output logic start2_out,
    output logic busy
);

    localparam logic [CNT_W-1:0] COIN_LOAD  = CNT_W'(COIN_FRAMES);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_FRAMES);
    localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(START_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    seq_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       coins_left, coins_nxt;
    player_t          player, player_nxt;
    logic             req1_q, req2_q;
    logic             coin_nxt, start1_nxt, start2_nxt;
    logic             frame_tick;
    logic             edge1, edge2;
    logic             phase_done;

    vblank_tick u_vblank_tick (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .ce_pix  (ce_pix),
        .vblank  (vblank),
        .tick    (frame_tick)
    );

    assign edge1      = ce_pix & req_start1 & ~req1_q;
    assign edge2      = ce_pix & req_start2 & ~req2_q;
    assign phase_done = frame_tick && (cnt == CNT_ONE);
    assign busy       = (state != IDLE);

    // History resets to 1 so a request still held when reset releases is not a fresh press.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            req1_q <= 1'b1;
            req2_q <= 1'b1;
        end else if (ce_pix) begin
            req1_q <= req_start1;
            req2_q <= req_start2;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            coins_left <= 2'd0;
            player     <= PLAYER_1;
            coin_out   <= 1'b0;
            start1_out <= 1'b0;
            start2_out <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            coins_left <= coins_nxt;
            player     <= player_nxt;
            coin_out   <= coin_nxt;
            start1_out <= start1_nxt;
            start2_out <= start2_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        coins_nxt  = coins_left;
        player_nxt = player;
        case (state)
            IDLE: begin
                if (edge1 || edge2) begin
                    state_nxt  = COIN_ON;
                    cnt_nxt    = COIN_LOAD;
                    coins_nxt  = edge2 ? 2'd2 : 2'd1;
                    player_nxt = edge2 ? PLAYER_2 : PLAYER_1;
                end
            end
            COIN_ON: begin
                if (phase_done) begin
                    state_nxt = COIN_GAP;
                    cnt_nxt   = GAP_LOAD;
                    coins_nxt = coins_left - 2'd1;
                end else if (frame_tick && cnt != '0) begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            COIN_GAP: begin
                if (phase_done) begin
                    if (coins_left != 2'd0) begin
                        state_nxt = COIN_ON;
                        cnt_nxt   = COIN_LOAD;
                    end else begin
                        state_nxt = START_ON;
                        cnt_nxt   = START_LOAD;
                    end
                end else if (frame_tick && cnt != '0) begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            START_ON: begin
                if (phase_done) begin
                    state_nxt = RELEASE;
                    cnt_nxt   = '0;
                end else if (frame_tick && cnt != '0) begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            RELEASE: begin
                if (ce_pix && !req_start1 && !req_start2) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they move on the same edge as the state.
    always_comb begin
        coin_nxt   = 1'b0;
        start1_nxt = 1'b0;
        start2_nxt = 1'b0;
        case (state_nxt)
            IDLE:     coin_nxt = ce_pix ? coin_btn : coin_out;
            COIN_ON:  coin_nxt = 1'b1;
            START_ON: begin
                start1_nxt = (player_nxt == PLAYER_1);
                start2_nxt = (player_nxt == PLAYER_2);
            end
            default: begin
                coin_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_coin_start_sequencer.sv
// tb/tb_coin_start_sequencer.sv - randomized scoreboard bench for coin_start_sequencer
module tb_coin_start_sequencer;

    localparam int COIN_F  = 3;
    localparam int GAP_F   = 5;
    localparam int START_F = 3;

    // Output vector order: {coin_out, start1_out, start2_out, busy}
    localparam logic [3:0] V_IDLE = 4'b0000;
    localparam logic [3:0] V_BTN  = 4'b1000;
    localparam logic [3:0] V_COIN = 4'b1001;
    localparam logic [3:0] V_GAP  = 4'b0001;
    localparam logic [3:0] V_ST1  = 4'b0101;
    localparam logic [3:0] V_ST2  = 4'b0011;
    localparam logic [3:0] V_REL  = 4'b0001;

    logic clk_sys    = 1'b0;
    logic reset_n    = 1'b0;
    logic ce_pix     = 1'b0;
    logic vblank     = 1'b0;
    logic req_start1 = 1'b0;
    logic req_start2 = 1'b0;
    logic coin_btn   = 1'b0;
    logic coin_out, start1_out, start2_out, busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] vec;
        int         ticks;
    } seg_t;

    seg_t       exp_q[$];
    seg_t       cur;
    int         tick_cnt = 0;
    logic [3:0] last_vec = 4'b0000;
    bit         mon_en   = 1'b0;
    bit         vb_prev  = 1'b0;

    coin_start_sequencer dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ce_pix     (ce_pix),
        .vblank     (vblank),
        .req_start1 (req_start1),
        .req_start2 (req_start2),
        .coin_btn   (coin_btn),
        .coin_out   (coin_out),
        .start1_out (start1_out),
        .start2_out (start2_out),
        .busy       (busy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Frame source: random frame lengths, random ce_pix density.
    initial begin
        int pos = 0;
        int len = 30;
        int vbl = 6;
        forever begin
            @(posedge clk_sys);
            #2;
            pos++;
            if (pos >= len) begin
                pos = 0;
                len = $urandom_range(20, 40);
                vbl = $urandom_range(4, 8);
            end
            vblank = (pos < vbl);
            ce_pix = ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: frame ticks per output segment, compared against queued expectations.
    initial begin
        logic [3:0] vec;
        bit         tick_now;
        cur = '{V_IDLE, -1};
        forever begin
            @(negedge clk_sys);
            tick_now = reset_n && ce_pix && vblank && !vb_prev;
            if (!reset_n) vb_prev = 1'b0;
            else if (ce_pix) vb_prev = vblank;
            if (mon_en) begin
                vec = {coin_out, start1_out, start2_out, busy};
                if (vec !== last_vec) begin
                    if (cur.ticks >= 0) check($sformatf("ticks_in_%b", cur.vec), tick_cnt, cur.ticks);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_change: actual=%b required=%b", vec, last_vec);
                        cur = '{vec, -1};
                    end else begin
                        cur = exp_q.pop_front();
                        check("segment_vec", vec, cur.vec);
                    end
                    last_vec = vec;
                    tick_cnt = 0;
                end
                if (tick_now) tick_cnt++;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    task automatic wait_ce();
        int n = 0;
        forever begin
            @(posedge clk_sys);
            if (ce_pix) break;
            n++;
            if (n > 200) begin timeout("ce_pix"); break; end
        end
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(exp_q.size() == 0 && last_vec == V_IDLE)) begin
            @(posedge clk_sys);
            n++;
            if (n > 5000) begin timeout("idle"); exp_q.delete(); break; end
        end
        #1;
    endtask

    task automatic wait_seg(input logic [3:0] v, input int t, input bit leave, input string name);
        int n = 0;
        while ((cur.vec == v && cur.ticks == t) == leave) begin
            @(posedge clk_sys);
            n++;
            if (n > 3000) begin timeout(name); break; end
        end
        #1;
    endtask

    task automatic push_seq(input bit two);
        exp_q.push_back('{V_COIN, COIN_F});
        exp_q.push_back('{V_GAP, GAP_F});
        if (two) begin
            exp_q.push_back('{V_COIN, COIN_F});
            exp_q.push_back('{V_GAP, GAP_F});
            exp_q.push_back('{V_ST2, START_F});
        end else begin
            exp_q.push_back('{V_ST1, START_F});
        end
        exp_q.push_back('{V_REL, -1});
        exp_q.push_back('{V_IDLE, -1});
    endtask

    // kind: 0 = start1, 1 = start2, 2 = both on the same cycle
    task automatic run_seq(input int kind, input bit hold, input bit poke);
        push_seq(kind != 0);
        if (kind == 0) req_start1 = 1'b1;
        else if (kind == 1) req_start2 = 1'b1;
        else begin req_start1 = 1'b1; req_start2 = 1'b1; end
        wait_ce();
        if (!hold) begin req_start1 = 1'b0; req_start2 = 1'b0; end
        if (poke) begin
            wait_seg(V_GAP, GAP_F, 1'b0, "enter_gap");
            coin_btn = 1'b1;
            if (kind == 0) begin
                req_start2 = 1'b1;
                wait_ce();
                req_start2 = 1'b0;
            end
            wait_seg(V_GAP, GAP_F, 1'b1, "leave_gap");
            coin_btn = 1'b0;
        end
        if (hold) begin
            wait_seg(V_REL, -1, 1'b0, "enter_release");
            repeat (150) @(posedge clk_sys);
            #1;
            check("release_wait_vec", {coin_out, start1_out, start2_out, busy}, V_REL);
            req_start1 = 1'b0;
            req_start2 = 1'b0;
        end
        wait_idle();
    endtask

    task automatic coin_passthru();
        exp_q.push_back('{V_BTN, -1});
        coin_btn = 1'b1;
        wait_ce();
        check("coin_mirror_hi", coin_out, 1'b1);
        repeat ($urandom_range(1, 5)) @(posedge clk_sys);
        #1;
        exp_q.push_back('{V_IDLE, -1});
        coin_btn = 1'b0;
        wait_ce();
        check("coin_mirror_lo", coin_out, 1'b0);
        wait_idle();
    endtask

    task automatic reset_test();
        push_seq(1'b1);
        req_start2 = 1'b1;
        wait_ce();
        req_start2 = 1'b0;
        wait_seg(V_COIN, COIN_F, 1'b0, "enter_coin");
        repeat (3) @(posedge clk_sys);
        #3;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check("async_rst_coin", coin_out, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_st1", start1_out, 1'b0);
        check("async_rst_st2", start2_out, 1'b0);
        exp_q.delete();
        req_start1 = 1'b1;
        repeat (4) @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        check("post_rst_vec", {coin_out, start1_out, start2_out, busy}, V_IDLE);
        cur      = '{V_IDLE, -1};
        last_vec = V_IDLE;
        tick_cnt = 0;
        mon_en   = 1'b1;
        repeat (200) @(posedge clk_sys);
        #1;
        check("held_req_no_edge", busy, 1'b0);
        req_start1 = 1'b0;
        repeat (30) @(posedge clk_sys);
        #1;
    endtask

    initial begin
        repeat (4) @(posedge clk_sys);
        #1;
        check("reset_coin", coin_out, 1'b0);
        check("reset_st1", start1_out, 1'b0);
        check("reset_st2", start2_out, 1'b0);
        check("reset_busy", busy, 1'b0);
        reset_n = 1'b1;
        repeat (30) @(posedge clk_sys);
        #1;
        last_vec = {coin_out, start1_out, start2_out, busy};
        mon_en   = 1'b1;

        run_seq(0, 1'b0, 1'b0);
        run_seq(1, 1'b0, 1'b0);
        run_seq(2, 1'b0, 1'b0);
        coin_passthru();
        run_seq(0, 1'b1, 1'b0);
        run_seq(0, 1'b0, 1'b1);
        run_seq(1, 1'b0, 1'b1);
        coin_passthru();
        for (int i = 0; i < 4; i++) begin
            run_seq($urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        reset_test();
        run_seq(0, 1'b0, 1'b0);
        run_seq(1, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
